adpll_hop_seq: RTL
==================

// Module: adpll_hop_seq
// PURPOSE
// - CPU-programmable channel sequencer and loop-coefficient register bank for the ADPLL control core.
// - Holds the channel table and the loop coefficients alpha/beta/lambda/iir_n/FCW_mod.
// - Steps through channels: drives FCW and adpll_mode, holds the ADPLL in reset between hops, waits for channel_lock with a timeout, then dwells.
// - Sits between the CPU bus and the ADPLL control core.
// PARAMETERS
// - NCH_MAX  8   channel-table depth, power of 2, <=8
// - CNTW     16  width of the dwell and timeout counters
// - GAPW     8   width of the inter-hop gap counter
// PORTS
// - clk          in   1   clock
// - rst          in   1   reset, asynchronous, active-high
// - en           in   1   clock enable; all state holds when 0
// - select       in   1   CPU access strobe
// - write        in   1   1=write, 0=read (qualified by select)
// - adress       in   5   CPU word address
// - data_in      in   32  CPU write data
// - data_out     out  32  CPU read data, registered
// - fcw          out  26  FCW to ADPLL, 12.14 fixed-point
// - adpll_mode   out  2   0=off, 2=RX, 3=TX
// - adpll_rst    out  1   synchronous-level reset to ADPLL core
// - channel_lock in   1   lock flag from ADPLL core
// - coef_alpha_l/alpha_m/alpha_s_rx/alpha_s_tx/beta  out 4 each  loop coefficients
// - coef_lambda_rx/lambda_tx out 3 each; coef_iir_n_rx/iir_n_tx out 2 each; coef_fcw_mod out 5
// - busy         out  1   sequence running
// - hop_pulse    out  1   1-cycle pulse at each dwell end
// - lock_err     out  1   sticky: a channel timed out
// BEHAVIOUR
// - Reset values: all registers 0, including data_out=0, fcw=0, adpll_mode=0, busy=0, hop_pulse=0, lock_err=0.
// - Coefficient reset values: alpha_l=14, alpha_m=8, alpha_s_rx=7, alpha_s_tx=4, beta=0, lambda=2/2, iir_n=3/2, fcw_mod=9.
// - adpll_rst=1 at reset.
// - CPU write: on posedge when select&write&en.
// - CPU read: select&~write registers data_out next posedge (1-cycle latency); unmapped addresses read 0.
// - Register map:
//   - 0x00 CTRL: wr-only bit0 start, bit1 stop, bit2 loop (stored).
//   - 0x01 STATUS: ro {lock_err, busy, state[2:0], ch_idx[2:0]}.
//   - 0x02 DWELL[CNTW-1:0]; 0x03 TIMEOUT[CNTW-1:0]; 0x04 GAP[GAPW-1:0]; 0x05 NCH[2:0] (last index).
//   - 0x06 COEF1 {beta,alpha_s_tx,alpha_s_rx,alpha_m,alpha_l}[19:0].
//   - 0x07 COEF2 {fcw_mod,iir_n_tx,iir_n_rx,lambda_tx,lambda_rx}[14:0].
//   - 0x08+i CH[i] {tx bit26, fcw[25:0]}.
//   - Any write to STATUS clears lock_err.
// - FSM states:
//   - IDLE: adpll_rst=1, mode=0. Start -> LOAD with ch_idx=0 and busy=1.
//   - LOAD: latch CH[ch_idx] into fcw and tx_sel; clear counters -> GAP.
//   - GAP: adpll_rst=1, mode=0; count GAP cycles (GAP=0 gives 1 cycle) -> ACQ.
//   - ACQ: adpll_rst=0, mode = tx_sel ? 3 : 2; tcnt++.
//     - channel_lock=1 -> DWELL.
//     - tcnt==TIMEOUT -> set lock_err, go to NEXT. TIMEOUT=0 disables the timeout.
//   - DWELL: hold mode; dcnt++; dcnt==DWELL -> hop_pulse, go to NEXT.
//   - NEXT:
//     - ch_idx<NCH -> ch_idx++, go to LOAD.
//     - else loop=1 -> ch_idx=0, go to LOAD.
//     - else -> IDLE, busy=0.
// - Edge cases:
//   - Stop is taken in any state: go to IDLE next cycle, adpll_rst=1 at once on that edge. Start and stop in the same write: stop wins.
//   - Start while busy is ignored.
//   - Writes to CH[] or COEF while busy take effect on the next LOAD, or immediately for COEF.
//   - fcw stays stable within a hop.
//   - Counters saturate and never wrap.
//   - NCH >= NCH_MAX is clipped to NCH_MAX-1.
//   - Async rst mid-sequence: everything returns to reset values at once.
// STRUCTURE
// - adpll_pkg: FCWW/INTW/FRAW, register address constants, FSM state encoding, mode constants RX=2, TX=3.
// - Sub-module adpll_cpu_regs: register file, channel table and read mux.
// - The FSM and counters stay in adpll_hop_seq.
// TESTING
// 1. Reset then read COEF1 -> data_out=0x0478E one cycle after the read; adpll_rst=1; mode=0.
// 2. NCH=1, CH0=0x0A00000 (RX), CH1=0x4B00000 (TX), GAP=3, DWELL=10, lock 5 cycles into each ACQ.
//    -> mode 2 then 3, two hop_pulse, busy falls, fcw = each entry.
// 3. TIMEOUT=20, channel_lock held 0 -> lock_err=1 after 20 ACQ cycles, next channel loaded; write STATUS clears it.
// 4. loop=1, NCH=0 -> hops repeat on CH0; stop mid-DWELL -> IDLE next cycle, adpll_rst=1, no hop_pulse.
// 5. CTRL=0x3 (start and stop together) -> stays IDLE. Start during busy -> ch_idx unaffected.
// 6. Assert rst in ACQ -> all outputs at reset values at once; en=0 for 10 cycles mid-DWELL -> dcnt frozen.

Source files
------------

// File: rtl/adpll_pkg.sv
// Shared constants, FSM encoding and coefficient layout for the ADPLL hop sequencer.
package adpll_pkg;

    localparam int INTW = 12;
    localparam int FRAW = 14;
    localparam int FCWW = INTW + FRAW;

    localparam logic [4:0] A_CTRL    = 5'h00;
    localparam logic [4:0] A_STATUS  = 5'h01;
    localparam logic [4:0] A_DWELL   = 5'h02;
    localparam logic [4:0] A_TIMEOUT = 5'h03;
    localparam logic [4:0] A_GAP     = 5'h04;
    localparam logic [4:0] A_NCH     = 5'h05;
    localparam logic [4:0] A_COEF1   = 5'h06;
    localparam logic [4:0] A_COEF2   = 5'h07;
    localparam logic [4:0] A_CH_BASE = 5'h08;

    localparam logic [1:0] MODE_OFF = 2'd0;
    localparam logic [1:0] MODE_RX  = 2'd2;
    localparam logic [1:0] MODE_TX  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_GAP   = 3'd2,
        S_ACQ   = 3'd3,
        S_DWELL = 3'd4,
        S_NEXT  = 3'd5
    } state_t;

    // Field order makes bits [19:0] the COEF1 word and bits [34:20] the COEF2 word.
    typedef struct packed {
        logic [4:0] fcw_mod;
        logic [1:0] iir_n_tx;
        logic [1:0] iir_n_rx;
        logic [2:0] lambda_tx;
        logic [2:0] lambda_rx;
        logic [3:0] beta;
        logic [3:0] alpha_s_tx;
        logic [3:0] alpha_s_rx;
        logic [3:0] alpha_m;
        logic [3:0] alpha_l;
    } coef_t;

    localparam coef_t COEF_RST = '{
        fcw_mod:    5'd9,
        iir_n_tx:   2'd2,
        iir_n_rx:   2'd3,
        lambda_tx:  3'd2,
        lambda_rx:  3'd2,
        beta:       4'd0,
        alpha_s_tx: 4'd4,
        alpha_s_rx: 4'd7,
        alpha_m:    4'd8,
        alpha_l:    4'd14
    };

endpackage

// File: rtl/adpll_cpu_regs.sv
// CPU register bank for the hop sequencer: configuration, coefficients, channel table and read mux.
module adpll_cpu_regs
    import adpll_pkg::*;
#(
    parameter int NCH_MAX = 8,
    parameter int CNTW    = 16,
    parameter int GAPW    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              select,
    input  logic              write,
    input  logic [4:0]        adress,
    input  logic [31:0]       data_in,
    output logic [31:0]       data_out,
    input  logic              st_lock_err,
    input  logic              st_busy,
    input  logic [2:0]        st_state,
    input  logic [2:0]        st_ch_idx,
    output logic              ctrl_start,
    output logic              ctrl_stop,
    output logic              status_wr,
    output logic              loop,
    output logic [CNTW-1:0]   dwell_len,
    output logic [CNTW-1:0]   timeout_len,
    output logic [GAPW-1:0]   gap_len,
    output logic [2:0]        nch,
    output logic [FCWW:0]     ch_word,
    output coef_t             coef
);

    localparam int IDXW = (NCH_MAX > 1) ? $clog2(NCH_MAX) : 1;

    logic [FCWW:0] ch_tbl [NCH_MAX];
    logic          wr_en;
    logic          rd_en;
    logic          is_ch;
    logic [31:0]   rd_mux;
    logic          unused_data_bits;

    function automatic logic [2:0] clip_nch(input logic [2:0] v);
        return (int'(v) >= NCH_MAX) ? 3'(NCH_MAX - 1) : v;
    endfunction

    assign wr_en = select & write & en;
    assign rd_en = select & ~write & en;
    assign is_ch = (adress[4:3] == A_CH_BASE[4:3]) && (int'(adress[2:0]) < NCH_MAX);

    assign ctrl_start = wr_en && (adress == A_CTRL) && data_in[0];
    assign ctrl_stop  = wr_en && (adress == A_CTRL) && data_in[1];
    assign status_wr  = wr_en && (adress == A_STATUS);
    assign ch_word    = ch_tbl[st_ch_idx[IDXW-1:0]];

    assign unused_data_bits = &{1'b0, data_in[31:FCWW+1]};

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            loop        <= 1'b0;
            dwell_len   <= '0;
            timeout_len <= '0;
            gap_len     <= '0;
            nch         <= '0;
            coef        <= COEF_RST;
            // NOTE: the channel table is reset because a read after reset must return 0, not X.
            for (int i = 0; i < NCH_MAX; i++) ch_tbl[i] <= '0;
        end else if (wr_en) begin
            case (adress)
                A_CTRL:    loop        <= data_in[2];
                A_DWELL:   dwell_len   <= data_in[CNTW-1:0];
                A_TIMEOUT: timeout_len <= data_in[CNTW-1:0];
                A_GAP:     gap_len     <= data_in[GAPW-1:0];
                A_NCH:     nch         <= clip_nch(data_in[2:0]);
                A_COEF1:   coef[19:0]  <= data_in[19:0];
                A_COEF2:   coef[34:20] <= data_in[14:0];
                default:   if (is_ch) ch_tbl[adress[IDXW-1:0]] <= data_in[FCWW:0];
            endcase
        end
    end

    // NOTE: rd_mux gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        rd_mux = '0;
        case (adress)
            A_STATUS:  rd_mux = {24'd0, st_lock_err, st_busy, st_state, st_ch_idx};
            A_DWELL:   rd_mux = 32'(dwell_len);
            A_TIMEOUT: rd_mux = 32'(timeout_len);
            A_GAP:     rd_mux = 32'(gap_len);
            A_NCH:     rd_mux = 32'(nch);
            A_COEF1:   rd_mux = {12'd0, coef[19:0]};
            A_COEF2:   rd_mux = {17'd0, coef[34:20]};
            default:   if (is_ch) rd_mux = 32'(ch_tbl[adress[IDXW-1:0]]);
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        data_out <= '0;
        else if (rd_en) data_out <= rd_mux;
    end

endmodule

// File: rtl/adpll_hop_seq.sv
// ADPLL hop sequencer: walks the channel table, holding the ADPLL in reset between hops,
// waiting for lock with an optional timeout, then dwelling before the next hop.
module adpll_hop_seq
    import adpll_pkg::*;
#(
    parameter int NCH_MAX = 8,
    parameter int CNTW    = 16,
    parameter int GAPW    = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            select,
    input  logic            write,
    input  logic [4:0]      adress,
    input  logic [31:0]     data_in,
    output logic [31:0]     data_out,
    output logic [FCWW-1:0] fcw,
    output logic [1:0]      adpll_mode,
    output logic            adpll_rst,
    input  logic            channel_lock,
    output logic [3:0]      coef_alpha_l,
    output logic [3:0]      coef_alpha_m,
    output logic [3:0]      coef_alpha_s_rx,
    output logic [3:0]      coef_alpha_s_tx,
    output logic [3:0]      coef_beta,
    output logic [2:0]      coef_lambda_rx,
    output logic [2:0]      coef_lambda_tx,
    output logic [1:0]      coef_iir_n_rx,
    output logic [1:0]      coef_iir_n_tx,
    output logic [4:0]      coef_fcw_mod,
    output logic            busy,
    output logic            hop_pulse,
    output logic            lock_err
);

    state_t          state, state_nxt;
    logic [2:0]      ch_idx;
    logic            tx_sel;
    logic [GAPW-1:0] gcnt, gcnt_inc;
    logic [GAPW:0]   gcnt_p1;
    logic [CNTW-1:0] tcnt, tcnt_inc;
    logic [CNTW-1:0] dcnt, dcnt_inc;
    logic            gap_done, acq_timeout, dwell_done, timeout_hit;

    logic            start, stop, status_wr, loop;
    logic [CNTW-1:0] dwell_len, timeout_len;
    logic [GAPW-1:0] gap_len;
    logic [2:0]      nch;
    logic [FCWW:0]   ch_word;
    coef_t           coef;

    adpll_cpu_regs #(
        .NCH_MAX (NCH_MAX),
        .CNTW    (CNTW),
        .GAPW    (GAPW)
    ) u_regs (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .select      (select),
        .write       (write),
        .adress      (adress),
        .data_in     (data_in),
        .data_out    (data_out),
        .st_lock_err (lock_err),
        .st_busy     (busy),
        .st_state    (state),
        .st_ch_idx   (ch_idx),
        .ctrl_start  (start),
        .ctrl_stop   (stop),
        .status_wr   (status_wr),
        .loop        (loop),
        .dwell_len   (dwell_len),
        .timeout_len (timeout_len),
        .gap_len     (gap_len),
        .nch         (nch),
        .ch_word     (ch_word),
        .coef        (coef)
    );

    assign coef_alpha_l    = coef.alpha_l;
    assign coef_alpha_m    = coef.alpha_m;
    assign coef_alpha_s_rx = coef.alpha_s_rx;
    assign coef_alpha_s_tx = coef.alpha_s_tx;
    assign coef_beta       = coef.beta;
    assign coef_lambda_rx  = coef.lambda_rx;
    assign coef_lambda_tx  = coef.lambda_tx;
    assign coef_iir_n_rx   = coef.iir_n_rx;
    assign coef_iir_n_tx   = coef.iir_n_tx;
    assign coef_fcw_mod    = coef.fcw_mod;

    // Saturating increments; GAP=0 still spends one cycle in GAP.
    assign gcnt_inc    = (gcnt == '1) ? gcnt : gcnt + 1'b1;
    assign tcnt_inc    = (tcnt == '1) ? tcnt : tcnt + 1'b1;
    assign dcnt_inc    = (dcnt == '1) ? dcnt : dcnt + 1'b1;
    assign gcnt_p1     = {1'b0, gcnt} + 1'b1;
    assign gap_done    = gcnt_p1 >= {1'b0, gap_len};
    assign acq_timeout = (timeout_len != '0) && (tcnt_inc == timeout_len);
    assign dwell_done  = dcnt_inc >= dwell_len;
    assign timeout_hit = (state == S_ACQ) && !stop && !channel_lock && acq_timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)     state <= S_IDLE;
        else if (en) state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (stop) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start) state_nxt = S_LOAD;
                S_LOAD:  state_nxt = S_GAP;
                S_GAP:   if (gap_done) state_nxt = S_ACQ;
                S_ACQ:   if (channel_lock) state_nxt = S_DWELL;
                         else if (acq_timeout) state_nxt = S_NEXT;
                S_DWELL: if (dwell_done) state_nxt = S_NEXT;
                S_NEXT:  state_nxt = (ch_idx < nch || loop) ? S_LOAD : S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        adpll_rst  = 1'b1;
        adpll_mode = MODE_OFF;
        busy       = (state != S_IDLE);
        case (state)
            S_ACQ, S_DWELL: begin
                adpll_rst  = 1'b0;
                adpll_mode = tx_sel ? MODE_TX : MODE_RX;
            end
            default: ;
        endcase
    end

    // fcw/tx_sel change only in LOAD, so they stay stable for the whole hop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_idx    <= '0;
            fcw       <= '0;
            tx_sel    <= 1'b0;
            gcnt      <= '0;
            tcnt      <= '0;
            dcnt      <= '0;
            lock_err  <= 1'b0;
            hop_pulse <= 1'b0;
        end else begin
            hop_pulse <= en && (state == S_DWELL) && !stop && dwell_done;
            if (en) begin
                case (state)
                    S_IDLE:  if (start) ch_idx <= '0;
                    S_LOAD: begin
                        fcw    <= ch_word[FCWW-1:0];
                        tx_sel <= ch_word[FCWW];
                        gcnt   <= '0;
                        tcnt   <= '0;
                        dcnt   <= '0;
                    end
                    S_GAP:   gcnt <= gcnt_inc;
                    S_ACQ:   tcnt <= tcnt_inc;
                    S_DWELL: dcnt <= dcnt_inc;
                    S_NEXT: begin
                        if (!stop) begin
                            if (ch_idx < nch) ch_idx <= ch_idx + 1'b1;
                            else if (loop)    ch_idx <= '0;
                        end
                    end
                    default: ;
                endcase
                if (timeout_hit)    lock_err <= 1'b1;
                else if (status_wr) lock_err <= 1'b0;
            end
        end
    end

endmodule
